// File: rtl/eth_fcs_tx_ctrl.sv
`default_nettype none
// eth_fcs_tx_ctrl: Ethernet TX framer (preamble, SFD, payload, pad, FCS, IFG) sequencing a byte-wide CRC-32 engine.
// Rev 1.0
module eth_fcs_tx_ctrl #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_LEN      = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_stb,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        tx_en,
  output logic [7:0]  txd,
  output logic        tx_er,
  output logic        frame_done,
  output logic        underrun,
  output logic        crc_load_init,
  output logic        crc_calc,
  output logic        crc_d_valid,
  output logic [7:0]  crc_data,
  input  logic [31:0] crc_reg_in
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_PAD  = 3'd3,
    S_FCS  = 3'd4,
    S_IFG  = 3'd5
  } state_t;

  localparam logic [15:0] PRE_W = 16'(PREAMBLE_LEN);
  localparam logic [16:0] MIN_W = 17'(MIN_FRAME);
  localparam logic [16:0] IFG_W = 17'(IFG_LEN);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d, cnt_inc;
  logic [16:0] cnt_p1;
  logic [7:0]  txd_d;
  logic        tx_en_d, tx_er_d, done_d, ur_d;
  logic        load_c, calc_c, dv_c;
  logic [7:0]  data_c;
  logic        unused_crc_low;

  // FCS bytes go out LSB first, so the engine's MSB byte is complemented and bit-reversed.
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign cnt_inc        = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign cnt_p1         = {1'b0, cnt} + 17'd1;
  assign unused_crc_low = ^crc_reg_in[23:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      txd        <= '0;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      txd        <= txd_d;
      tx_en      <= tx_en_d;
      tx_er      <= tx_er_d;
      frame_done <= done_d;
      underrun   <= ur_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    txd_d   = txd;
    tx_en_d = tx_en;
    tx_er_d = tx_er;
    done_d  = 1'b0;
    ur_d    = 1'b0;
    load_c  = 1'b0;
    calc_c  = 1'b0;
    dv_c    = 1'b0;
    data_c  = 8'h00;
    case (state)
      S_IDLE: begin
        tx_en_d = 1'b0;
        tx_er_d = 1'b0;
        if (s_tvalid) begin
          load_c  = 1'b1;
          cnt_d   = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (byte_stb) begin
          tx_en_d = 1'b1;
          tx_er_d = 1'b0;
          if (cnt < PRE_W) begin
            txd_d = 8'h55;
            cnt_d = cnt_inc;
          end else begin
            txd_d   = 8'hD5;
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_stb) begin
          tx_en_d = 1'b1;
          if (s_tvalid) begin
            txd_d   = s_tdata;
            tx_er_d = 1'b0;
            calc_c  = 1'b1;
            dv_c    = 1'b1;
            data_c  = s_tdata;
            cnt_d   = cnt_inc;
            if (s_tlast) begin
              if (cnt_p1 < MIN_W) begin
                state_d = S_PAD;
              end else begin
                cnt_d   = '0;
                state_d = S_FCS;
              end
            end
          end else begin
            // Underrun: one errored byte, then straight to the gap with no FCS.
            txd_d   = 8'h00;
            tx_er_d = 1'b1;
            ur_d    = 1'b1;
            cnt_d   = '0;
            state_d = S_IFG;
          end
        end
      end
      S_PAD: begin
        if (byte_stb) begin
          txd_d   = 8'h00;
          tx_en_d = 1'b1;
          calc_c  = 1'b1;
          dv_c    = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_p1 >= MIN_W) begin
            cnt_d   = '0;
            state_d = S_FCS;
          end
        end
      end
      S_FCS: begin
        if (byte_stb) begin
          txd_d   = bitrev8(~crc_reg_in[31:24]);
          tx_en_d = 1'b1;
          dv_c    = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt == 16'd3) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IFG;
          end
        end
      end
      S_IFG: begin
        if (byte_stb) begin
          tx_en_d = 1'b0;
          tx_er_d = 1'b0;
          if (cnt_p1 >= IFG_W) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign s_tready      = rst_n & (state == S_DATA) & byte_stb;
  assign crc_load_init = rst_n & load_c;
  assign crc_calc      = rst_n & calc_c;
  assign crc_d_valid   = rst_n & dv_c;
  assign crc_data      = rst_n ? data_c : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_eth_fcs_tx_ctrl.sv
`default_nettype none
// tb_eth_fcs_tx_ctrl: random-payload bench with a CRC engine model and a frame-level reference.
module tb_eth_fcs_tx_ctrl;

  localparam int PRE_LEN = 7;
  localparam int MIN_FR  = 60;
  localparam int IFG_N   = 12;
  localparam int BUDGET  = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_stb = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready, tx_en, tx_er, frame_done, underrun;
  logic [7:0]  txd;
  logic        crc_load_init, crc_calc, crc_d_valid;
  logic [7:0]  crc_data;
  logic [31:0] crc_reg = 32'h0;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [7:0]  pay[$];

  eth_fcs_tx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .byte_stb(byte_stb),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .tx_en(tx_en), .txd(txd), .tx_er(tx_er), .frame_done(frame_done), .underrun(underrun),
    .crc_load_init(crc_load_init), .crc_calc(crc_calc), .crc_d_valid(crc_d_valid),
    .crc_data(crc_data), .crc_reg_in(crc_reg)
  );

  always #5 clk = ~clk;

  // External engine: MSB-first register, data bits consumed LSB first.
  function automatic logic [31:0] eng_step(input logic [31:0] r_in, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = r_in;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (crc_load_init)    crc_reg <= 32'hFFFFFFFF;
    else if (crc_d_valid) crc_reg <= crc_calc ? eng_step(crc_reg, crc_data) : {crc_reg[23:0], 8'hFF};
  end

  // Reference IEEE 802.3 FCS, reflected table-free form.
  function automatic logic [31:0] ref_fcs(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'd0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic gen_stb(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 4) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fill_rand(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  task automatic run_frame(input int mode, input int ur_at, input bit rst_fcs);
    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];
    logic [7:0]  crc_in[$];
    logic [8:0]  prev;
    logic [31:0] fcs, got_fcs, r;
    int len, sent, budget, n_done, n_ur, n_dv_bad, n_hold_bad, nbad, n, n_en_bad, n_early;
    bit stb_now, rdy, first, rst_done;
    len = pay.size(); sent = 0; budget = 0; n_done = 0; n_ur = 0; n_dv_bad = 0;
    n_hold_bad = 0; nbad = 0; first = 1'b1; rst_done = 1'b0; fcs = '0;
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    if (ur_at >= 0) begin
      for (int i = 0; i < ur_at; i++) exp_q.push_back({1'b0, pay[i]});
      exp_q.push_back({1'b1, 8'h00});
    end else begin
      crc_in = pay;
      while (crc_in.size() < MIN_FR) crc_in.push_back(8'h00);
      foreach (crc_in[i]) exp_q.push_back({1'b0, crc_in[i]});
      fcs = ref_fcs(crc_in);
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, fcs[8*i +: 8]});
    end
    prev = {tx_er, txd};
    while (got_q.size() < exp_q.size() && budget < BUDGET && !rst_done) begin
      @(negedge clk);
      cyc++;
      byte_stb = gen_stb(mode);
      if (sent < len && sent != ur_at) begin
        s_tvalid = 1'b1; s_tdata = pay[sent]; s_tlast = (sent == len - 1);
      end else begin
        s_tvalid = 1'b0; s_tdata = 8'($urandom); s_tlast = 1'($urandom);
      end
      if (rst_fcs && got_q.size() == exp_q.size() - 3) begin
        rst_n = 1'b0; byte_stb = 1'b1;
      end
      #1;
      if (first) begin
        check("idle_load_init", crc_load_init, 1);
        first = 1'b0;
      end
      if (crc_d_valid && !byte_stb) n_dv_bad++;
      rdy = s_tready; stb_now = byte_stb;
      @(posedge clk);
      if (s_tvalid && rdy) sent++;
      #1;
      if (!rst_n) begin
        check("rst_mid_fcs_txen", tx_en, 0);
        check("rst_mid_fcs_done", frame_done, 0);
        rst_done = 1'b1;
      end else begin
        if (stb_now && tx_en) got_q.push_back({tx_er, txd});
        if (!stb_now && {tx_er, txd} !== prev) n_hold_bad++;
        prev = {tx_er, txd};
        if (frame_done) n_done++;
        if (underrun) n_ur++;
        budget++;
      end
    end
    if (rst_fcs) begin
      @(negedge clk);
      rst_n = 1'b1; byte_stb = 1'b0; s_tvalid = 1'b0;
      check("rst_reached", rst_done, 1);
      return;
    end
    check("frame_budget", budget < BUDGET, 1);
    check("frame_nbytes", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nbad++;
    check("frame_bytes_bad", nbad, 0);
    check("frame_done_pulses", n_done, (ur_at >= 0) ? 0 : 1);
    check("underrun_pulses", n_ur, (ur_at >= 0) ? 1 : 0);
    check("dvalid_without_stb", n_dv_bad, 0);
    check("hold_between_stb", n_hold_bad, 0);
    n = got_q.size();
    if (ur_at < 0 && n >= 12) begin
      got_fcs = {got_q[n-1][7:0], got_q[n-2][7:0], got_q[n-3][7:0], got_q[n-4][7:0]};
      check("fcs_value", got_fcs, fcs);
      r = 32'hFFFFFFFF;
      for (int i = PRE_LEN + 1; i < n; i++) r = eng_step(r, got_q[i][7:0]);
      check("fcs_residue", r, 32'hC704DD7B);
    end
    // Gap: IFG_N strobes with tx_en low; a valid offered before the last one must not start a frame.
    n = 0; n_en_bad = 0; n_early = 0; budget = 0;
    while (n < IFG_N && budget < BUDGET) begin
      @(negedge clk);
      cyc++;
      byte_stb = gen_stb(mode);
      s_tvalid = (n == IFG_N - 1);
      #1;
      if (crc_load_init) n_early++;
      stb_now = byte_stb;
      @(posedge clk);
      #1;
      if (stb_now) begin
        n++;
        if (tx_en || tx_er) n_en_bad++;
      end
      budget++;
    end
    check("ifg_budget", budget < BUDGET, 1);
    check("ifg_txen_low", n_en_bad, 0);
    check("ifg_early_start", n_early, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, ur;
    rst_n = 1'b0; byte_stb = 1'b1; s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_regs", {tx_en, tx_er, frame_done, underrun, txd}, 0);
    check("reset_comb", {s_tready, crc_load_init, crc_calc, crc_d_valid, crc_data}, 0);
    @(negedge clk);
    rst_n = 1'b1; byte_stb = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    run_frame(0, -1, 1'b0);
    run_frame(1, -1, 1'b0);
    fill_rand(64); run_frame(0, -1, 1'b0);
    fill_rand(60); run_frame(2, -1, 1'b0);
    fill_rand(59); run_frame(2, -1, 1'b0);
    fill_rand(1);  run_frame(0, -1, 1'b0);
    fill_rand(30); run_frame(0, 20, 1'b0);
    fill_rand(40); run_frame(0, -1, 1'b1);
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    run_frame(0, -1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 100);
      ur  = (len >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      fill_rand(len);
      run_frame(int'($urandom_range(0, 2)), ur, 1'b0);
    end
    @(negedge clk);
    s_tvalid = 1'b0; byte_stb = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
